// File: rtl/junofirst_snd_pkg.sv
// Shared types and constants for the Juno First sound-board AY RC filter.
// Holds the FSM state encoding, cap-select codes and default filter coefficients.
package junofirst_snd_pkg;

    localparam int FRAC_W = 16;

    // Q0.16 coefficients for the three selectable capacitances at 96 kHz.
    localparam logic [15:0] K_47N_DEF  = 16'd15270;
    localparam logic [15:0] K_220N_DEF = 16'd3606;
    localparam logic [15:0] K_267N_DEF = 16'd2989;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_A = 3'd1,
        ACC_A = 3'd2,
        MUL_B = 3'd3,
        ACC_B = 3'd4,
        MUL_C = 3'd5,
        ACC_C = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAP_NONE = 2'b00,
        CAP_47N  = 2'b01,
        CAP_220N = 2'b10,
        CAP_267N = 2'b11
    } cap_sel_t;

    function automatic logic [15:0] cap_coef(input cap_sel_t sel,
                                             input logic [15:0] k47,
                                             input logic [15:0] k220,
                                             input logic [15:0] k267);
        logic [15:0] k;
        k = 16'd0;
        case (sel)
            CAP_47N:  k = k47;
            CAP_220N: k = k220;
            CAP_267N: k = k267;
            default:  k = 16'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/junofirst_ay_rcfilt_if.sv
// Sample-side bus of the AY RC filter: sample enable, raw levels, port B, filtered outputs.
// valid/ready: there is no ready; cen is accepted only in IDLE, out_valid is a one-cycle strobe.
interface junofirst_ay_rcfilt_if;
    import junofirst_snd_pkg::*;

    logic        cen;
    logic [7:0]  ay_a;
    logic [7:0]  ay_b;
    logic [7:0]  ay_c;
    logic [7:0]  ay_portb;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_c;
    logic        out_valid;
    state_t      dbg_state;

    modport master (
        output cen, ay_a, ay_b, ay_c, ay_portb,
        input  out_a, out_b, out_c, out_valid, dbg_state
    );

    modport slave (
        input  cen, ay_a, ay_b, ay_c, ay_portb,
        output out_a, out_b, out_c, out_valid, dbg_state
    );

endinterface

// File: rtl/junofirst_rc_mac.sv
// Shared one-pole RC datapath: registered (x - s) * k product, then the state update.
// The product is captured while mul_en is high and consumed on the following cycle.
module junofirst_rc_mac
    import junofirst_snd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               mul_en,
    input  logic [15:0]        x,
    input  logic signed [31:0] s,
    input  logic [15:0]        k,
    input  logic               bypass,
    output logic signed [31:0] s_next
);

    logic signed [32:0] d;
    logic signed [16:0] k_ext;
    logic signed [49:0] prod_d;
    logic signed [49:0] prod_q;

    always_comb begin
        d      = $signed({1'b0, x, 16'd0}) - $signed({s[31], s});
        k_ext  = $signed({1'b0, k});
        prod_d = mul_en ? d * k_ext : prod_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    // The state never leaves [0, 8160<<16], so wrapping 32-bit addition is exact.
    always_comb begin
        if (bypass) begin
            s_next = {x, 16'd0};
        end else begin
            s_next = s + 32'(prod_q >>> FRAC_W);
        end
    end

endmodule

// File: rtl/junofirst_ay_rcfilt.sv
// Switchable RC low-pass for the three AY channels, one MAC time-shared per sample.
// Inputs are snapshotted on the accepted cen; outputs update together on the last step.
module junofirst_ay_rcfilt
    import junofirst_snd_pkg::*;
#(
    parameter logic [15:0] K_47N  = K_47N_DEF,
    parameter logic [15:0] K_220N = K_220N_DEF,
    parameter logic [15:0] K_267N = K_267N_DEF
) (
    input  logic                   clk_49m,
    input  logic                   rst,
    junofirst_ay_rcfilt_if.slave   bus
);

    state_t             state_q, state_d;
    logic [7:0]         xa_q, xa_d, xb_q, xb_d, xc_q, xc_d;
    logic [5:0]         sel_q, sel_d;
    logic signed [31:0] s_a_q, s_a_d, s_b_q, s_b_d, s_c_q, s_c_d;
    logic [15:0]        out_a_q, out_a_d, out_b_q, out_b_d, out_c_q, out_c_d;
    logic               out_valid_q, out_valid_d;

    logic [15:0]        ch_x;
    cap_sel_t           ch_sel;
    logic signed [31:0] ch_s;
    logic               mul_en;
    logic signed [31:0] s_next;

    // Channel steering follows the FSM; MUL and ACC of a channel see the same operands.
    always_comb begin
        case (state_q)
            MUL_B, ACC_B: begin
                ch_x   = {3'd0, xb_q, 5'd0};
                ch_sel = cap_sel_t'(sel_q[3:2]);
                ch_s   = s_b_q;
            end
            MUL_C, ACC_C: begin
                ch_x   = {3'd0, xc_q, 5'd0};
                ch_sel = cap_sel_t'(sel_q[5:4]);
                ch_s   = s_c_q;
            end
            default: begin
                ch_x   = {3'd0, xa_q, 5'd0};
                ch_sel = cap_sel_t'(sel_q[1:0]);
                ch_s   = s_a_q;
            end
        endcase
        mul_en = (state_q == MUL_A) || (state_q == MUL_B) || (state_q == MUL_C);
    end

    junofirst_rc_mac u_mac (
        .clk    (clk_49m),
        .rst    (rst),
        .mul_en (mul_en),
        .x      (ch_x),
        .s      (ch_s),
        .k      (cap_coef(ch_sel, K_47N, K_220N, K_267N)),
        .bypass (ch_sel == CAP_NONE),
        .s_next (s_next)
    );

    always_comb begin
        state_d     = state_q;
        xa_d        = xa_q;
        xb_d        = xb_q;
        xc_d        = xc_q;
        sel_d       = sel_q;
        s_a_d       = s_a_q;
        s_b_d       = s_b_q;
        s_c_d       = s_c_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cen) begin
                    xa_d    = bus.ay_a;
                    xb_d    = bus.ay_b;
                    xc_d    = bus.ay_c;
                    sel_d   = bus.ay_portb[5:0];
                    state_d = MUL_A;
                end
            end
            MUL_A: state_d = ACC_A;
            ACC_A: begin
                s_a_d   = s_next;
                state_d = MUL_B;
            end
            MUL_B: state_d = ACC_B;
            ACC_B: begin
                s_b_d   = s_next;
                state_d = MUL_C;
            end
            MUL_C: state_d = ACC_C;
            ACC_C: begin
                s_c_d       = s_next;
                out_a_d     = s_a_q[31:16];
                out_b_d     = s_b_q[31:16];
                out_c_d     = s_next[31:16];
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_49m) begin
        if (rst) begin
            state_q     <= IDLE;
            xa_q        <= '0;
            xb_q        <= '0;
            xc_q        <= '0;
            sel_q       <= '0;
            s_a_q       <= '0;
            s_b_q       <= '0;
            s_c_q       <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            xa_q        <= xa_d;
            xb_q        <= xb_d;
            xc_q        <= xc_d;
            sel_q       <= sel_d;
            s_a_q       <= s_a_d;
            s_b_q       <= s_b_d;
            s_c_q       <= s_c_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_junofirst_ay_rcfilt.sv
// Directed bench for junofirst_ay_rcfilt: reset, bypass, filtered steps, snapshot,
// busy cen and mid-sample reset, with a scoreboard of expected {out_a, out_b, out_c}.
module tb_junofirst_ay_rcfilt;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    junofirst_ay_rcfilt_if bus();

    junofirst_ay_rcfilt dut (
        .clk_49m (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int          n_cmp     = 0;
    int          n_err     = 0;
    int          valid_cnt = 0;
    logic [47:0] exp_q[$];
    logic [47:0] mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected triple.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            valid_cnt++;
            check("sb_expected_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sb_out_a", bus.out_a, mon_e[47:32]);
                check("sb_out_b", bus.out_b, mon_e[31:16]);
                check("sb_out_c", bus.out_c, mon_e[15:0]);
            end
        end
    end

    task automatic set_in(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] pb);
        bus.ay_a     = a;
        bus.ay_b     = b;
        bus.ay_c     = c;
        bus.ay_portb = pb;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_cen();
        bus.cen = 1'b1;
        @(negedge clk);
        bus.cen = 1'b0;
    endtask

    task automatic wait_valid();
        int cyc;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("valid_seen", bus.out_valid, 1);
        @(negedge clk);
    endtask

    task automatic run_sample(input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
        exp_q.push_back({ea, eb, ec});
        pulse_cen();
        wait_valid();
    endtask

    task automatic do_reset(input int n);
        exp_q.delete();
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.cen = i[0] ? 1'b0 : 1'b1;
            @(negedge clk);
            check("rst_valid_low", bus.out_valid, 0);
        end
        rst     = 1'b0;
        bus.cen = 1'b0;
        tick(1);
    endtask

    function automatic longint rc_step(input longint s, input longint x, input longint k);
        longint d;
        d = (x <<< 16) - s;
        return s + ((d * k) >>> 16);
    endfunction

    initial begin
        int          c0;
        longint      ma, mc;
        logic [15:0] prev_a, ea, ec;

        bus.cen = 1'b0;
        set_in(8'd0, 8'd0, 8'd0, 8'd0);
        tick(1);

        // Reset with cen pulsing
        do_reset(3);
        check("rst_out_a", bus.out_a, 0);
        check("rst_out_b", bus.out_b, 0);
        check("rst_out_c", bus.out_c, 0);
        check("rst_state", bus.dbg_state, 0);

        // Bypass step with exact latency and strobe width
        set_in(8'd255, 8'd0, 8'd0, 8'd0);
        exp_q.push_back({16'd8160, 16'd0, 16'd0});
        pulse_cen();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("valid_before_e6", bus.out_valid, 0);
        end
        @(negedge clk);
        check("valid_at_e6", bus.out_valid, 1);
        check("bypass_out_a", bus.out_a, 8160);
        @(negedge clk);
        check("valid_width", bus.out_valid, 0);
        tick(1);

        // Filtered step: A 47 nF, B bypass, C 220 nF
        do_reset(2);
        set_in(8'd255, 8'd255, 8'd255, 8'b0010_0001);
        run_sample(16'd1901, 16'd8160, 16'd448);
        run_sample(16'd3359, 16'd8160, 16'd873);
        ma     = 64'sd220173641;
        mc     = 64'sd57230864;
        prev_a = bus.out_a;
        for (int i = 0; i < 58; i++) begin
            ma = rc_step(ma, 8160, 15270);
            mc = rc_step(mc, 8160, 3606);
            ea = 16'(ma >>> 16);
            ec = 16'(mc >>> 16);
            run_sample(ea, 16'd8160, ec);
            check("mono_a", bus.out_a >= prev_a, 1);
            check("cap_a", bus.out_a <= 16'd8160, 1);
            prev_a = bus.out_a;
        end
        check("settle_a", bus.out_a, 8159);

        // Snapshot stability: inputs change after the snapshot edge
        do_reset(2);
        set_in(8'd100, 8'd50, 8'd200, 8'd0);
        exp_q.push_back({16'd3200, 16'd1600, 16'd6400});
        pulse_cen();
        @(negedge clk);
        set_in(8'd7, 8'd50, 8'd200, 8'b0001_0101);
        wait_valid();
        run_sample(16'd2506, 16'd1600, 16'd6400);

        // cen while busy is dropped
        exp_q.push_back({16'd1974, 16'd1600, 16'd6400});
        c0 = valid_cnt;
        pulse_cen();
        tick(2);
        bus.cen = 1'b1;
        @(negedge clk);
        bus.cen = 1'b0;
        wait_valid();
        tick(12);
        check("busy_one_valid", valid_cnt - c0, 1);
        check("busy_no_update", bus.out_a, 1974);

        // Reset in the middle of a sample
        set_in(8'd255, 8'd255, 8'd255, 8'b0010_0001);
        c0 = valid_cnt;
        pulse_cen();
        tick(3);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_valid", bus.out_valid, 0);
        end
        rst = 1'b0;
        tick(10);
        check("abort_no_valid", valid_cnt - c0, 0);
        check("abort_out_a", bus.out_a, 0);
        check("abort_out_b", bus.out_b, 0);
        check("abort_out_c", bus.out_c, 0);
        run_sample(16'd1901, 16'd8160, 16'd448);

        tick(2);
        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
